// File: rtl/soc_apb_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to APB4 bridge.
// Optional feature macro: SOC_APB_BRIDGE_TIMEOUT_EN (ACCESS-phase timeout).
package soc_apb_bridge_pkg;

    // One address rule: [start_addr, end_addr) maps to APB slot idx.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} fsm_state_e;

    // Side that wins when a read and a write are both eligible.
    typedef enum logic {PRIO_READ = 1'b0, PRIO_WRITE = 1'b1} prio_e;

    // Request latched at grant and held on the APB pins until the next grant.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        write;
    } apb_req_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [1:0]  RESP_DECERR   = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_apb_addr_decoder.sv
// Combinational address decoder: first matching rule (lowest index) wins.
// Rules pointing at a slot that does not exist are treated as non-matching.
module soc_apb_addr_decoder
    import soc_apb_bridge_pkg::*;
#(
    parameter int NR_APB_SLAVES = 4,
    parameter int NR_ADDR_RULES = 4,
    parameter int IDX_W         = (NR_APB_SLAVES > 1) ? $clog2(NR_APB_SLAVES) : 1
) (
    input  logic [31:0]                        addr_i,
    input  addr_map_rule_t [NR_ADDR_RULES-1:0] addr_map_i,
    output logic [IDX_W-1:0]                   idx_o,
    output logic                               hit_o
);

    // Scan from the highest rule down so the lowest matching index is the last write.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NR_ADDR_RULES - 1; i >= 0; i--) begin
            if (addr_i >= addr_map_i[i].start_addr && addr_i < addr_map_i[i].end_addr &&
                addr_map_i[i].idx < 32'(NR_APB_SLAVES)) begin
                hit_o = 1'b1;
                idx_o = addr_map_i[i].idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/soc_axi_lite_to_apb.sv
// AXI-Lite slave to APB4 master bridge, one transaction in flight.
// Optional feature macro: SOC_APB_BRIDGE_TIMEOUT_EN (aborts ACCESS after TIMEOUT_CYCLES).
module soc_axi_lite_to_apb
    import soc_apb_bridge_pkg::*;
#(
    parameter int NR_APB_SLAVES  = 4,
    parameter int NR_ADDR_RULES  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  addr_map_rule_t [NR_ADDR_RULES-1:0]   addr_map_i,
    input  logic [31:0]                          axi_aw_addr,
    input  logic [2:0]                           axi_aw_prot,
    input  logic                                 axi_aw_valid,
    output logic                                 axi_aw_ready,
    input  logic [31:0]                          axi_w_data,
    input  logic [3:0]                           axi_w_strb,
    input  logic                                 axi_w_valid,
    output logic                                 axi_w_ready,
    output logic [1:0]                           axi_b_resp,
    output logic                                 axi_b_valid,
    input  logic                                 axi_b_ready,
    input  logic [31:0]                          axi_ar_addr,
    input  logic [2:0]                           axi_ar_prot,
    input  logic                                 axi_ar_valid,
    output logic                                 axi_ar_ready,
    output logic [31:0]                          axi_r_data,
    output logic [1:0]                           axi_r_resp,
    output logic                                 axi_r_valid,
    input  logic                                 axi_r_ready,
    output logic [31:0]                          paddr_o,
    output logic [31:0]                          pwdata_o,
    output logic                                 pwrite_o,
    output logic [2:0]                           pprot_o,
    output logic [3:0]                           pstrb_o,
    output logic [NR_APB_SLAVES-1:0]             psel_o,
    output logic                                 penable_o,
    input  logic [NR_APB_SLAVES-1:0][31:0]       prdata_i,
    input  logic [NR_APB_SLAVES-1:0]             pready_i,
    input  logic [NR_APB_SLAVES-1:0]             pslverr_i,
    output logic                                 busy_o
);

    localparam int IDX_W = (NR_APB_SLAVES > 1) ? $clog2(NR_APB_SLAVES) : 1;

    fsm_state_e        state_q, state_d;
    prio_e             prio_q;
    apb_req_t          req_q;
    logic [IDX_W-1:0]  idx_q, dec_idx;
    logic [1:0]        resp_q;
    logic [31:0]       rdata_q, dec_addr;
    logic              wr_elig, rd_elig, grant_wr, grant_rd, dec_hit;
    logic              sel_ready, timeout;

    // A write needs AW and W together; AW alone never wins.
    assign wr_elig  = axi_aw_valid & axi_w_valid;
    assign rd_elig  = axi_ar_valid;
    assign grant_wr = (state_q == IDLE) & wr_elig & (~rd_elig | (prio_q == PRIO_WRITE));
    assign grant_rd = (state_q == IDLE) & rd_elig & ~grant_wr;
    assign dec_addr = grant_wr ? axi_aw_addr : axi_ar_addr;

    assign axi_aw_ready = grant_wr;
    assign axi_w_ready  = grant_wr;
    assign axi_ar_ready = grant_rd;

    soc_apb_addr_decoder #(
        .NR_APB_SLAVES (NR_APB_SLAVES),
        .NR_ADDR_RULES (NR_ADDR_RULES),
        .IDX_W         (IDX_W)
    ) u_dec (
        .addr_i     (dec_addr),
        .addr_map_i (addr_map_i),
        .idx_o      (dec_idx),
        .hit_o      (dec_hit)
    );

    // Only the selected slot's ready/error/data are ever looked at.
    assign sel_ready = pready_i[idx_q];

`ifdef SOC_APB_BRIDGE_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    assign timeout = (state_q == ACCESS) & ~sel_ready & (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles spent waiting; cleared while in SETUP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                  to_cnt_q <= '0;
        else if (state_q == SETUP)                  to_cnt_q <= '0;
        else if (state_q == ACCESS && !sel_ready)   to_cnt_q <= to_cnt_q + 16'd1;
    end
`else
    logic to_param_unused;
    assign to_param_unused = (TIMEOUT_CYCLES > 0);
    assign timeout         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Flip the priority flag only when both sides competed for the grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                        prio_q <= PRIO_READ;
        else if ((grant_wr | grant_rd) & wr_elig & rd_elig) prio_q <= (prio_q == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
    end

    // Latch the request at grant; capture the response at the end of ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q   <= '0;
            idx_q   <= '0;
            resp_q  <= RESP_OKAY;
            rdata_q <= '0;
        end else if (grant_wr | grant_rd) begin
            req_q.addr  <= dec_addr;
            req_q.prot  <= grant_wr ? axi_aw_prot : axi_ar_prot;
            req_q.wdata <= grant_wr ? axi_w_data : '0;
            req_q.strb  <= grant_wr ? axi_w_strb : '0;
            req_q.write <= grant_wr;
            idx_q       <= dec_idx;
            resp_q      <= dec_hit ? RESP_OKAY : RESP_DECERR;
            rdata_q     <= '0;
        end else if (state_q == ACCESS) begin
            if (timeout) begin
                resp_q  <= RESP_SLVERR;
                rdata_q <= TIMEOUT_RDATA;
            end else if (sel_ready) begin
                resp_q  <= pslverr_i[idx_q] ? RESP_SLVERR : RESP_OKAY;
                rdata_q <= req_q.write ? '0 : prdata_i[idx_q];
            end
        end
    end

    // Next state and APB/AXI handshake outputs.
    always_comb begin
        state_d     = state_q;
        psel_o      = '0;
        penable_o   = 1'b0;
        axi_b_valid = 1'b0;
        axi_r_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_wr | grant_rd) state_d = dec_hit ? SETUP : RESP;
            end
            SETUP: begin
                psel_o[idx_q] = 1'b1;
                state_d       = ACCESS;
            end
            ACCESS: begin
                psel_o[idx_q] = 1'b1;
                penable_o     = 1'b1;
                if (sel_ready | timeout) state_d = RESP;
            end
            RESP: begin
                axi_b_valid = req_q.write;
                axi_r_valid = ~req_q.write;
                if (req_q.write ? axi_b_ready : axi_r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign paddr_o    = req_q.addr;
    assign pwdata_o   = req_q.wdata;
    assign pwrite_o   = req_q.write;
    assign pprot_o    = req_q.prot;
    assign pstrb_o    = req_q.strb;
    assign axi_b_resp = resp_q;
    assign axi_r_resp = resp_q;
    assign axi_r_data = rdata_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_soc_axi_lite_to_apb.sv
// Self-checking bench for soc_axi_lite_to_apb: directed steps plus random traffic
// against a transaction-level reference model and a simple APB slave model.
module tb_soc_axi_lite_to_apb;
    import soc_apb_bridge_pkg::*;

    localparam int NS = 4;
    localparam int NR = 4;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addr_map_rule_t [NR-1:0] addr_map;
    logic [31:0] aw_addr, w_data, ar_addr, r_data, paddr, pwdata;
    logic [2:0]  aw_prot, ar_prot, pprot;
    logic [3:0]  w_strb, pstrb;
    logic [1:0]  b_resp, r_resp;
    logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic ar_valid, ar_ready, r_valid, r_ready, pwrite, penable, busy;
    logic [NS-1:0]       psel, pready, pslverr;
    logic [NS-1:0][31:0] prdata;

    soc_axi_lite_to_apb #(.NR_APB_SLAVES(NS), .NR_ADDR_RULES(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map),
        .axi_aw_addr(aw_addr), .axi_aw_prot(aw_prot), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
        .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_valid(w_valid), .axi_w_ready(w_ready),
        .axi_b_resp(b_resp), .axi_b_valid(b_valid), .axi_b_ready(b_ready),
        .axi_ar_addr(ar_addr), .axi_ar_prot(ar_prot), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
        .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_valid(r_valid), .axi_r_ready(r_ready),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .pprot_o(pprot), .pstrb_o(pstrb),
        .psel_o(psel), .penable_o(penable), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
        .busy_o(busy)
    );

    int checks = 0;
    int failures = 0;

    // Slave model configuration for the current transaction.
    int          cfg_waits = 0;
    bit          cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_cnt   = 0;
    bit          model_prio_wr = 1'b0;

    // Count ACCESS cycles the slave has stalled.
    always @(posedge clk) begin
        if (!penable)                    acc_cnt <= 0;
        else if (!(|(psel & pready)))    acc_cnt <= acc_cnt + 1;
    end

    // Selected slot follows the configuration; idle slots drive misleading values.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            if (psel[s]) begin
                pready[s]  = penable && (acc_cnt >= cfg_waits);
                pslverr[s] = cfg_err;
                prdata[s]  = cfg_rdata;
            end else begin
                pready[s]  = 1'b1;
                pslverr[s] = 1'b1;
                prdata[s]  = 32'hBAD0_0000 | 32'(s);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: walk the rule table in order, first hit wins.
    function automatic void model_decode(input logic [31:0] a, output bit hit, output int slot);
        hit = 1'b0;
        slot = 0;
        for (int i = 0; i < NR; i++)
            if (!hit && a >= addr_map[i].start_addr && a < addr_map[i].end_addr) begin
                hit = 1'b1;
                slot = int'(addr_map[i].idx);
            end
    endfunction

    task automatic set_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input logic [2:0] pr);
        if (wr) begin
            aw_addr = a; aw_prot = pr; w_data = d; w_strb = st; aw_valid = 1'b1; w_valid = 1'b1;
        end else begin
            ar_addr = a; ar_prot = pr; ar_valid = 1'b1;
        end
    endtask

    task automatic clr_req(input bit wr);
        if (wr) begin aw_valid = 1'b0; w_valid = 1'b0; end
        else    ar_valid = 1'b0;
    endtask

    // Returns the number of cycles until the grant, or -1 if it never came.
    task automatic wait_grant(input bit wr, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr ? (aw_ready && w_ready) : ar_ready) begin t = i; break; end
        end
    endtask

    // Entered at the grant negedge; leaves at posedge+1 after the response handshake.
    task automatic run_resp(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, input logic [2:0] pr, input int rdy_delay);
        bit hit; int slot; int exp_lat; int cyc; bit seen; bit trace_ok;
        logic [1:0] exp_resp; logic [31:0] exp_rdata; logic [3:0] exp_psel; logic exp_pen;
        model_decode(a, hit, slot);
        exp_lat   = hit ? 3 + cfg_waits : 1;
        exp_resp  = !hit ? 2'b11 : (cfg_err ? 2'b10 : 2'b00);
        exp_rdata = (hit && !wr) ? cfg_rdata : 32'h0;
`ifdef SOC_APB_BRIDGE_TIMEOUT_EN
        if (hit && cfg_waits >= TO) begin
            exp_lat = 2 + TO; exp_resp = 2'b10; exp_rdata = 32'hDEAD_BEEF;
        end
`endif
        @(posedge clk); #1;
        clr_req(wr);
        cyc = 0; seen = 1'b0; trace_ok = 1'b1;
        while (!seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            exp_psel = (hit && cyc < exp_lat) ? (4'b0001 << slot) : 4'b0000;
            exp_pen  = hit && cyc >= 2 && cyc < exp_lat;
            if (psel !== exp_psel || penable !== exp_pen) trace_ok = 1'b0;
            if (exp_psel != 0 && (paddr !== a || pwrite !== wr || pprot !== pr)) trace_ok = 1'b0;
            if (exp_psel != 0 && wr && (pwdata !== d || pstrb !== st)) trace_ok = 1'b0;
            if (exp_psel != 0 && !wr && pstrb !== 4'h0) trace_ok = 1'b0;
            if (wr ? r_valid : b_valid) trace_ok = 1'b0;
            seen = wr ? b_valid : r_valid;
        end
        check({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "/resp"}, wr ? b_resp : r_resp, exp_resp);
        if (!wr) check({tag, "/rdata"}, r_data, exp_rdata);
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            if (!(wr ? b_valid : r_valid) || (wr ? b_resp : r_resp) !== exp_resp) trace_ok = 1'b0;
        end
        check({tag, "/apb_trace"}, trace_ok, 1'b1);
        if (wr) b_ready = 1'b1; else r_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0; r_ready = 1'b0;
        check({tag, "/idle_after"}, {busy, b_valid, r_valid}, 3'b000);
    endtask

    task automatic do_txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input logic [2:0] pr, input int waits, input bit err,
                          input logic [31:0] rd, input int rdy_delay);
        int t;
        cfg_waits = waits; cfg_err = err; cfg_rdata = rd;
        set_req(wr, a, d, st, pr);
        wait_grant(wr, t);
        check({tag, "/grant_cycle"}, 64'(t), 64'(0));
        if (t < 0) begin clr_req(wr); @(posedge clk); #1; return; end
        run_resp(tag, wr, a, d, st, pr, rdy_delay);
    endtask

    // Write and read presented in the same cycle; the model predicts who goes first.
    task automatic dual(input string tag);
        bit first_wr; int t;
        cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = $urandom;
        set_req(1'b1, 32'h2000_0010, 32'hA5A5_0001, 4'h3, 3'b001);
        set_req(1'b0, 32'h1A10_8004, 32'h0, 4'h0, 3'b010);
        first_wr = model_prio_wr;
        model_prio_wr = !model_prio_wr;
        @(negedge clk);
        check({tag, "/first_grant"}, {aw_ready && w_ready, ar_ready}, first_wr ? 2'b10 : 2'b01);
        if (first_wr) run_resp({tag, "_wr"}, 1'b1, 32'h2000_0010, 32'hA5A5_0001, 4'h3, 3'b001, 0);
        else          run_resp({tag, "_rd"}, 1'b0, 32'h1A10_8004, 32'h0, 4'h0, 3'b010, 0);
        wait_grant(!first_wr, t);
        check({tag, "/second_grant"}, 64'(t), 64'(0));
        if (t < 0) begin clr_req(1'b0); clr_req(1'b1); @(posedge clk); #1; return; end
        if (!first_wr) run_resp({tag, "_wr"}, 1'b1, 32'h2000_0010, 32'hA5A5_0001, 4'h3, 3'b001, 0);
        else           run_resp({tag, "_rd"}, 1'b0, 32'h1A10_8004, 32'h0, 4'h0, 3'b010, 0);
    endtask

    initial begin
        logic [31:0] bases [6];
        int t;
        bit bad;
        bases = '{32'h1A10_0000, 32'h1A10_8000, 32'h1A10_2000, 32'h2000_0000, 32'h0000_0000, 32'h3000_0000};

        // Rule 2 overlaps rules 0 and 1; the earlier rules must win.
        addr_map[0] = '{idx: 32'd1, start_addr: 32'h1A10_0000, end_addr: 32'h1A10_1000};
        addr_map[1] = '{idx: 32'd2, start_addr: 32'h1A10_2000, end_addr: 32'h1A10_3000};
        addr_map[2] = '{idx: 32'd0, start_addr: 32'h1A10_0000, end_addr: 32'h1A11_0000};
        addr_map[3] = '{idx: 32'd3, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000};
        aw_addr = '0; aw_prot = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0; b_ready = 0;
        ar_addr = '0; ar_prot = '0; ar_valid = 0; r_ready = 0;

        rst = 1'b1;
        #12;
        check("reset_ctrl", {aw_ready, w_ready, ar_ready, b_valid, r_valid, psel, penable, busy, pwrite, pstrb, pprot}, '0);
        check("reset_data", {paddr, pwdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_txn("wr_slot1", 1'b1, 32'h1A10_0004, 32'h1234_5678, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
        do_txn("rd_slot2_wait3_err", 1'b0, 32'h1A10_2000, 32'h0, 4'h0, 3'b011, 3, 1'b1, 32'hCAFE_F00D, 2);
        dual("dual1");
        dual("dual2");
        do_txn("rd_unmapped", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h1111_1111, 0);
        do_txn("wr_unmapped", 1'b1, 32'h0000_0000, 32'hFFFF_0000, 4'hC, 3'b000, 0, 1'b0, 32'h0, 1);
        do_txn("rd_end_excl", 1'b0, 32'h2000_1000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h2222_2222, 0);
        do_txn("rd_last_word", 1'b0, 32'h2000_0FFC, 32'h0, 4'h0, 3'b100, 1, 1'b0, 32'h3333_3333, 0);
        do_txn("wr_overlap_slot0", 1'b1, 32'h1A10_8000, 32'h0BAD_F00D, 4'h5, 3'b110, 2, 1'b0, 32'h0, 0);

        // AW without W must not be accepted.
        aw_addr = 32'h1A10_0004; aw_prot = 3'b000; aw_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (aw_ready || w_ready || psel != 0 || busy) bad = 1'b1;
        end
        check("aw_only/no_accept", bad, 1'b0);
        @(posedge clk); #1;
        cfg_waits = 0; cfg_err = 1'b0;
        set_req(1'b1, 32'h1A10_0004, 32'h5555_AAAA, 4'hF, 3'b000);
        wait_grant(1'b1, t);
        check("aw_then_w/grant_cycle", 64'(t), 64'(0));
        if (t >= 0) run_resp("aw_then_w", 1'b1, 32'h1A10_0004, 32'h5555_AAAA, 4'hF, 3'b000, 0);
        else begin clr_req(1'b1); @(posedge clk); #1; end

        for (int n = 0; n < 40; n++) begin
            bit wr; logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = bases[$urandom_range(0, 5)] + ($urandom_range(0, 1023) * 4);
            do_txn($sformatf("rand%0d", n), wr, a, $urandom, 4'($urandom), 3'($urandom),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
        end

        // Reset in the middle of ACCESS aborts the transfer with no response.
        cfg_waits = 10; cfg_err = 1'b0; cfg_rdata = 32'h7777_7777;
        set_req(1'b0, 32'h1A10_2010, 32'h0, 4'h0, 3'b000);
        wait_grant(1'b0, t);
        check("rst_mid/grant_cycle", 64'(t), 64'(0));
        @(posedge clk); #1;
        clr_req(1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_mid/in_access", {psel, penable}, 5'b0100_1);
        rst = 1'b1;
        #1;
        check("rst_mid/async_clear", {psel, penable, r_valid, b_valid, busy}, '0);
        model_prio_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; r_ready = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (r_valid || b_valid || psel != 0) bad = 1'b1;
        end
        check("rst_mid/no_late_resp", bad, 1'b0);
        @(posedge clk); #1;
        r_ready = 1'b0;
        do_txn("rd_after_rst", 1'b0, 32'h1A10_2010, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h8888_8888, 0);
        dual("dual_after_rst");

`ifdef SOC_APB_BRIDGE_TIMEOUT_EN
        do_txn("rd_timeout", 1'b0, 32'h1A10_2000, 32'h0, 4'h0, 3'b000, 100000, 1'b0, 32'h9999_9999, 0);
        do_txn("rd_after_timeout", 1'b0, 32'h1A10_0008, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'hABCD_0123, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
